// File: rtl/sop_mac_stream.sv
// sop_mac_stream -- streaming sum-of-products engine.
//
// Accepts one operand pair per cycle, multiplies it in a registered stage,
// accumulates the products, and after N_PAIRS accepted pairs presents the
// full-precision sum on a valid/ready output. A new dot-product starts
// automatically once the result has been taken.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous abort of the partial sum and any pending result
//   in_valid   operand pair valid
//   in_ready   pair accepted this cycle when in_valid is also high
//   in_a/in_b  operands (DATA_W bits, two's complement when SIGNED=1)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   result     sum of N_PAIRS products (RES_W bits)
//   busy       partial sum in progress or result pending
module sop_mac_stream #(
   parameter int DATA_W  = 4,
   parameter int N_PAIRS = 4,
   parameter int SIGNED  = 0,
   parameter int RES_W   = 2*DATA_W + $clog2(N_PAIRS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RES_W-1:0]  result,
   output logic              busy
);

   localparam int PROD_W = 2*DATA_W;
   localparam int CNT_W  = $clog2(N_PAIRS);
   localparam int EXT_W  = RES_W - PROD_W;

   typedef enum logic [1:0] {S_ACC, S_FLUSH, S_OUT} state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    count_q;
   logic [PROD_W-1:0]   prod_q;
   logic                prod_vld_q;
   logic [RES_W-1:0]    acc_q;
   logic [RES_W-1:0]    result_q;

   logic                accept;
   logic                last_pair;
   logic [PROD_W-1:0]   a_ext;
   logic [PROD_W-1:0]   b_ext;
   logic [PROD_W-1:0]   prod_d;
   logic [RES_W-1:0]    prod_ext;
   logic [RES_W-1:0]    sum_d;
   logic [CNT_W-1:0]    count_d;

   assign accept    = in_valid && in_ready;
   assign last_pair = (count_q == CNT_W'(N_PAIRS - 1));
   assign count_d   = last_pair ? '0 : count_q + CNT_W'(1);

   // Operands are widened to the product width first; the low PROD_W bits of
   // the widened product equal the true signed or unsigned product, which
   // always fits in PROD_W bits.
   always_comb begin
      a_ext    = '0;
      b_ext    = '0;
      prod_ext = '0;
      if (SIGNED != 0) begin
         a_ext    = {{DATA_W{in_a[DATA_W-1]}}, in_a};
         b_ext    = {{DATA_W{in_b[DATA_W-1]}}, in_b};
         prod_ext = {{EXT_W{prod_q[PROD_W-1]}}, prod_q};
      end else begin
         a_ext    = {{DATA_W{1'b0}}, in_a};
         b_ext    = {{DATA_W{1'b0}}, in_b};
         prod_ext = {{EXT_W{1'b0}}, prod_q};
      end
      prod_d = a_ext * b_ext;
      sum_d  = acc_q + prod_ext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_ACC;
         count_q    <= '0;
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
         result_q   <= '0;
      end else if (clear) begin
         // Abort wins over any handshake in the same cycle.
         state_q    <= S_ACC;
         count_q    <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
      end else begin
         prod_vld_q <= accept;
         if (accept) begin
            prod_q  <= prod_d;
            count_q <= count_d;
         end
         case (state_q)
            S_ACC: begin
               if (prod_vld_q) acc_q <= sum_d;
               if (accept && last_pair) state_q <= S_FLUSH;
            end
            S_FLUSH: begin
               // The last product is still in prod_q; fold it straight into
               // the result and leave the accumulator empty for the next run.
               result_q <= sum_d;
               acc_q    <= '0;
               state_q  <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) state_q <= S_ACC;
            end
            default: state_q <= S_ACC;
         endcase
      end
   end

   assign in_ready  = (state_q == S_ACC);
   assign out_valid = (state_q == S_OUT);
   assign result    = result_q;
   assign busy      = (count_q != '0) || prod_vld_q || (state_q != S_ACC);

endmodule

// File: tb/tb_sop_mac_stream.sv
module tb_sop_mac_stream;

   localparam int RW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_a;
   logic [3:0]    in_b;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] result;
   logic          busy;

   logic          s_clear;
   logic          s_in_valid;
   logic          s_in_ready;
   logic [3:0]    s_in_a;
   logic [3:0]    s_in_b;
   logic          s_out_valid;
   logic          s_out_ready;
   logic [RW-1:0] s_result;
   logic          s_busy;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] uq[$];
   logic [31:0] sq[$];

   always #5 clk = ~clk;

   sop_mac_stream #(.DATA_W(4), .N_PAIRS(4), .SIGNED(0)) u_dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
   );

   sop_mac_stream #(.DATA_W(4), .N_PAIRS(4), .SIGNED(1)) s_dut (
      .clk(clk), .rst(rst), .clear(s_clear),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result), .busy(s_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboards: an empty queue yields X, so an unexpected result fails.
   always @(negedge clk) begin
      logic [31:0] exp;
      if (!rst && !clear && out_valid && out_ready) begin
         if (uq.size() != 0) exp = uq.pop_front();
         else exp = 'x;
         check("u_result", {22'd0, result}, exp);
      end
      if (!rst && !s_clear && s_out_valid && s_out_ready) begin
         if (sq.size() != 0) exp = sq.pop_front();
         else exp = 'x;
         check("s_result", {22'd0, s_result}, exp);
      end
   end

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b);
      int w = 0;
      in_valid = 1'b1; in_a = a; in_b = b;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("u_send_accepted", {31'd0, (w < 50)}, 32'd1);
      drive_edge();
      in_valid = 1'b0;
   endtask

   task automatic send_s(input logic [3:0] a, input logic [3:0] b);
      int w = 0;
      s_in_valid = 1'b1; s_in_a = a; s_in_b = b;
      @(negedge clk);
      while (!s_in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("s_send_accepted", {31'd0, (w < 50)}, 32'd1);
      drive_edge();
      s_in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int w = 0;
      @(negedge clk);
      while ((busy || s_busy) && w < 40) begin
         @(negedge clk);
         w++;
      end
      check(tag, {31'd0, (w < 40)}, 32'd1);
      drive_edge();
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
      s_clear = 1'b0; s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", {22'd0, result}, 32'd0);
      drive_edge();

      // Unsigned max, back-to-back, out_ready high
      uq.push_back(32'd900);
      repeat (4) send(4'd15, 4'd15);
      @(negedge clk);
      check("max_flush_in_ready", {31'd0, in_ready}, 32'd0);
      check("max_flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("max_flush_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("max_out_valid", {31'd0, out_valid}, 32'd1);
      check("max_out_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check("max_after_in_ready", {31'd0, in_ready}, 32'd1);
      check("max_after_out_valid", {31'd0, out_valid}, 32'd0);
      check("max_after_busy", {31'd0, busy}, 32'd0);
      drive_edge();

      // Input gaps and output backpressure
      out_ready = 1'b0;
      uq.push_back(32'd100);
      send(4'd1, 4'd2);
      send(4'd3, 4'd4);
      drive_edge();
      send(4'd5, 4'd6);
      @(negedge clk);
      check("gap_busy", {31'd0, busy}, 32'd1);
      check("gap_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) drive_edge();
      send(4'd7, 4'd8);
      @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_result_held", {22'd0, result}, 32'd100);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      drive_edge();
      out_ready = 1'b1;
      @(negedge clk);
      drive_edge();
      @(negedge clk);
      check("bp_done_out_valid", {31'd0, out_valid}, 32'd0);
      check("bp_done_in_ready", {31'd0, in_ready}, 32'd1);
      drive_edge();

      // Clear mid-sum, with an in-flight pair in the clear cycle
      send(4'd15, 4'd15);
      send(4'd15, 4'd15);
      in_valid = 1'b1; in_a = 4'd3; in_b = 4'd3; clear = 1'b1;
      drive_edge();
      clear = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("clr_busy", {31'd0, busy}, 32'd0);
      check("clr_in_ready", {31'd0, in_ready}, 32'd1);
      drive_edge();
      uq.push_back(32'd4);
      repeat (4) send(4'd1, 4'd1);
      wait_idle("clr_idle");

      // Clear drops a pending result even with out_ready high
      out_ready = 1'b0;
      repeat (4) send(4'd2, 4'd2);
      @(negedge clk);
      @(negedge clk);
      check("drop_pending_valid", {31'd0, out_valid}, 32'd1);
      drive_edge();
      out_ready = 1'b1; clear = 1'b1;
      drive_edge();
      clear = 1'b0;
      @(negedge clk);
      check("drop_out_valid", {31'd0, out_valid}, 32'd0);
      check("drop_busy", {31'd0, busy}, 32'd0);
      drive_edge();

      // Asynchronous reset during FLUSH
      repeat (4) send(4'd5, 4'd5);
      #2;
      check("ar_pre_busy", {31'd0, busy}, 32'd1);
      check("ar_pre_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b1;
      #1;
      check("ar_out_valid", {31'd0, out_valid}, 32'd0);
      check("ar_busy", {31'd0, busy}, 32'd0);
      drive_edge();
      rst = 1'b0;
      uq.push_back(32'd24);
      repeat (4) send(4'd2, 4'd3);
      wait_idle("ar_idle");

      // Signed operands
      sq.push_back(32'h100);
      repeat (4) send_s(4'h8, 4'h8);
      sq.push_back(32'h320);
      repeat (4) send_s(4'h8, 4'h7);
      wait_idle("s_idle");

      check("u_sb_empty", uq.size(), 32'd0);
      check("s_sb_empty", sq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
